mainfsm: RTL

MAINFSM -- requirements
Module: mainfsm

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/mainfsm.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, ALU
// operation classes, datapath select codes and the controller state type.
package mips_pkg;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

endpackage

// File: rtl/mainfsm.sv
// Main control FSM of the multicycle MIPS datapath. Outputs are a pure
// decode of the state register (plus memready in FETCH and rst_n gating).
module mainfsm
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       memready,
   output logic [1:0] aluop,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       irwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       pcen
);

   state_t state, next_state;
   logic   pcwrite, branch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= next_state;
   end

   // op is only consulted in DECODE and MEMADR; memory states stall on memready.
   always_comb begin
      next_state = FETCH;
      case (state)
         FETCH:   next_state = memready ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_RTYPE:     next_state = RTYPEEX;
               OP_BEQ:       next_state = BEQEX;
               OP_ADDI:      next_state = ADDIEX;
               OP_J:         next_state = JEX;
               default:      next_state = FETCH;
            endcase
         end
         MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   next_state = memready ? MEMWB : MEMRD;
         MEMWB:   next_state = FETCH;
         MEMWR:   next_state = memready ? FETCH : MEMWR;
         RTYPEEX: next_state = RTYPEWB;
         RTYPEWB: next_state = FETCH;
         BEQEX:   next_state = FETCH;
         ADDIEX:  next_state = ADDIWB;
         ADDIWB:  next_state = FETCH;
         JEX:     next_state = FETCH;
         default: next_state = FETCH;
      endcase
   end

   always_comb begin
      aluop    = ALUOP_ADD;
      alusrca  = 1'b0;
      alusrcb  = SRCB_REGB;
      pcsrc    = PCSRC_ALU;
      iord     = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      case (state)
         FETCH: begin
            alusrcb = SRCB_FOUR;
            irwrite = memready;
            pcwrite = memready;
         end
         DECODE:  alusrcb = SRCB_IMMSH;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         MEMRD:   iord = 1'b1;
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PCSRC_ALUOUT;
            branch  = 1'b1;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         ADDIWB:  regwrite = 1'b1;
         JEX: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
      // During reset the state already reads FETCH; only the enables need masking.
      if (!rst_n) begin
         irwrite  = 1'b0;
         regwrite = 1'b0;
         memwrite = 1'b0;
         pcwrite  = 1'b0;
         branch   = 1'b0;
      end
   end

   assign pcen = pcwrite | (branch & zero);

endmodule
